// File: rtl/gate_test_sequencer.sv
// Sequencer that walks a 2-input gate through 00,10,11,01 and checks its output against EXPECT.
// Define GATE_SEQ_ABORT_EN to end a run at its first mismatch.
module gate_test_sequencer #(
  parameter int          DWELL_CYCLES = 10,
  parameter logic [3:0]  EXPECT       = 4'b1000,
  parameter int          CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] step_idx,
  output logic [1:0] fail_step
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] dwell;
  logic             sample;
  logic             mism;
  logic             last;
  logic [2:0]       err_nxt;

  // Gray walk: exactly one gate input toggles per step
  function automatic logic [1:0] pat(input logic [1:0] s);
    case (s)
      2'd0:    pat = 2'b00;
      2'd1:    pat = 2'b10;
      2'd2:    pat = 2'b11;
      default: pat = 2'b01;
    endcase
  endfunction

  always_comb begin
    sample  = (state == S_RUN) && (dwell == DW_LAST);
    mism    = sample && (gate_out != EXPECT[{gate_a, gate_b}]);
    err_nxt = err_count + {2'b00, mism};
`ifdef GATE_SEQ_ABORT_EN
    last    = (step_idx == 2'd3) || mism;
`else
    last    = (step_idx == 2'd3);
`endif
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dwell     <= '0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      step_idx  <= '0;
      fail_step <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          gate_a <= 1'b0;
          gate_b <= 1'b0;
          if (start) begin
            state     <= S_RUN;
            err_count <= '0;
            fail_step <= '0;
            pass      <= 1'b0;
            step_idx  <= '0;
            dwell     <= '0;
          end
        end
        S_RUN: begin
          if (sample) begin
            dwell <= '0;
            if (mism) begin
              err_count <= err_nxt;
              if (err_count == 3'd0) fail_step <= step_idx;
            end
            if (last) begin
              state             <= S_DONE;
              step_idx          <= '0;
              {gate_a, gate_b}  <= 2'b00;
              pass              <= (err_nxt == 3'd0);
            end else begin
              step_idx          <= step_idx + 2'd1;
              {gate_a, gate_b}  <= pat(step_idx + 2'd1);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          gate_a <= 1'b0;
          gate_b <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench for gate_test_sequencer: a model gate drives gate_out, expected run results are queued at start.
module tb_gate_test_sequencer;

  localparam int         D   = 10;
  localparam logic [3:0] EXP = 4'b1000;

  localparam logic [1:0] M_AND = 2'd0, M_OR = 2'd1, M_ST1 = 2'd2, M_ST0 = 2'd3;

  typedef struct {
    logic [2:0] err;
    logic [1:0] fs;
    logic       pass;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       gate_out;
  logic       gate_a, gate_b, busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] step_idx, fail_step;
  logic [1:0] mode;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic gate_fn(input logic [1:0] m, input logic a, input logic b);
    case (m)
      M_AND:   gate_fn = a & b;
      M_OR:    gate_fn = a | b;
      M_ST1:   gate_fn = 1'b1;
      default: gate_fn = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] pat(input int i);
    case (i)
      0:       pat = 2'b00;
      1:       pat = 2'b10;
      2:       pat = 2'b11;
      default: pat = 2'b01;
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] m);
    exp_t e;
    logic [1:0] p;
    e.err = 0; e.fs = 0; e.cyc = 4*D + 1;
    for (int i = 0; i < 4; i++) begin
      p = pat(i);
      if (gate_fn(m, p[1], p[0]) != EXP[p]) begin
        if (e.err == 0) e.fs = 2'(i);
        e.err = e.err + 3'd1;
`ifdef GATE_SEQ_ABORT_EN
        e.cyc = (i + 1)*D + 1;
        break;
`endif
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  assign gate_out = gate_fn(mode, gate_a, gate_b);

  gate_test_sequencer #(.DWELL_CYCLES(D), .EXPECT(EXP), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_out(gate_out),
    .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .step_idx(step_idx), .fail_step(fail_step)
  );

  // Called at a negedge; the following posedge accepts the start.
  task automatic launch(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    sb.push_back(model(m));
    @(negedge clk);
  endtask

  // Entered at the negedge of RUN cycle 1; tracks the run to its done pulse.
  task automatic follow(input string name, input int repulse, input bit keep);
    exp_t e;
    bit   seen = 0;
    int   idx;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty, actual 0 entries, required 1", name);
      return;
    end
    e = sb[0];
    for (int c = 1; c <= 4*D + 10 && !seen; c++) begin
      if (c == 1 && !keep) start = 1'b0;
      if (repulse != 0 && c == repulse) start = 1'b1;
      else if (repulse != 0 && c == repulse + 1 && !keep) start = 1'b0;
      if (done === 1'b1) begin
        seen = 1;
        void'(sb.pop_front());
        n_chk++;
        if (c !== e.cyc) begin
          n_fail++;
          $display("FAIL %s done_cycle: actual %0d required %0d", name, c, e.cyc);
        end
        n_chk++;
        if ({err_count, fail_step, pass} !== {e.err, e.fs, e.pass}) begin
          n_fail++;
          $display("FAIL %s result: actual err=%0d fs=%0d pass=%0b required err=%0d fs=%0d pass=%0b",
                   name, err_count, fail_step, pass, e.err, e.fs, e.pass);
        end
        n_chk++;
        if ({busy, gate_a, gate_b} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s done_outputs: actual busy,a,b=%b required 000", name, {busy, gate_a, gate_b});
        end
      end else begin
        idx = (c - 1) / D;
        n_chk++;
        if (!(busy === 1'b1 && {gate_a, gate_b} === pat(idx) && step_idx === 2'(idx))) begin
          n_fail++;
          $display("FAIL %s run_c%0d: actual busy=%b ab=%b step=%0d required busy=1 ab=%b step=%0d",
                   name, c, busy, {gate_a, gate_b}, step_idx, pat(idx), idx);
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: actual no done, required done in cycle %0d", name, e.cyc);
    end else if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s post_done: actual done,busy=%b required 00", name, {done, busy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = M_AND;
    #1;
    n_chk++;
    if ({gate_a, gate_b, busy, done, pass, err_count, step_idx, fail_step} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: actual %b required 0", {gate_a, gate_b, busy, done, pass, err_count, step_idx, fail_step});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and();
    launch(M_AND);
    follow("and_gate", 0, 0);
  endtask

  task automatic test_or();
    launch(M_OR);
    follow("or_gate", 0, 0);
  endtask

  task automatic test_stuck();
    launch(M_ST1);
    follow("stuck1", 0, 0);
    launch(M_ST0);
    follow("stuck0", 0, 0);
  endtask

  task automatic test_midrun_reset();
    launch(M_AND);
    start = 1'b0;
    repeat (24) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    n_chk++;
    if ({gate_a, gate_b, busy, done, pass, err_count, step_idx, fail_step} !== 12'd0) begin
      n_fail++;
      $display("FAIL midrun_reset_async: actual %b required 0", {gate_a, gate_b, busy, done, pass, err_count, step_idx, fail_step});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({done, pass, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL midrun_reset_hold: actual done,pass,busy=%b required 000", {done, pass, busy});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    launch(M_AND);
    follow("after_reset", 0, 0);
  endtask

  task automatic test_back_to_back();
    launch(M_AND);
    follow("repulse", 15, 0);
    launch(M_OR);
    follow("held_first", 0, 1);
    // start still high: this IDLE cycle's edge must accept the next run
    launch(M_AND);
    n_chk++;
    if ({busy, err_count, pass} !== 5'b1_000_0) begin
      n_fail++;
      $display("FAIL held_accept_clear: actual busy=%b err=%0d pass=%b required busy=1 err=0 pass=0", busy, err_count, pass);
    end
    follow("held_second", 0, 0);
  endtask

`ifdef GATE_SEQ_ABORT_EN
  task automatic test_abort();
    launch(M_ST1);
    follow("abort_stuck1", 0, 0);
    launch(M_OR);
    follow("abort_or", 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_and();
    test_or();
    test_stuck();
    test_midrun_reset();
    test_back_to_back();
`ifdef GATE_SEQ_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
